freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 16 +
 rtl/freq_meter_sync_edge.sv | 31 +++
 rtl/freq_meter.sv | 107 ++++++++++
 tb/tb_freq_meter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared defaults and gate FSM encoding for the frequency meter
package freq_meter_pkg;

  // Default clk frequency; one gate window is exactly this many clk cycles.
  localparam int unsigned CLK_HZ_DEF = 50_000_000;

  // Default width of the edge counter and of the reported frequency.
  localparam int unsigned CNT_W_DEF = 27;

  // Gate FSM: either idle or counting inside a gate window.
  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } gate_state_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// rtl/freq_meter_sync_edge.sv - 2-flop synchronizer with registered rising-edge pulse
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  // sync_q[0]/sync_q[1] are the metastability flops, sync_q[2] holds the previous synced level.
  logic [2:0] sync_q;
  // arm_q fills with ones after reset; the detector only fires once sync_q[2] holds a
  // post-reset sample, so a level already high at reset release never looks like an edge.
  logic [2:0] arm_q;
  logic       rise_q;

  // Synchronize sig_in and register a one-cycle pulse per synchronized rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      arm_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], sig_in};
      arm_q  <= {arm_q[1:0], 1'b1};
      rise_q <= sync_q[1] & ~sync_q[2] & arm_q[2];
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter reporting sig_in frequency once per window
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned       GATE_W    = $clog2(CLK_HZ);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  gate_state_t       state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [CNT_W-1:0]  edge_next;
  logic              sat_q;
  logic              sat_next;
  logic              gate_end;
  logic              rise;
  logic [CNT_W-1:0]  freq_q;
  logic              ovf_q;
  logic              valid_q;

  sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Gate FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle count update; the last gate cycle folds in its own edge.
  always_comb begin
    state_d   = state_q;
    edge_next = edge_cnt_q;
    sat_next  = sat_q;
    case (state_q)
      IDLE:    if (en)  state_d = GATE;
      GATE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_cnt_q + CNT_W'(1);
      end
    end
    gate_end = (state_q == GATE) && en && (gate_cnt_q == GATE_LAST);
  end

  // Gate and edge counters; cleared outside a gate, on abort and at every window boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else if (state_q != GATE || !en || gate_end) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      gate_cnt_q <= gate_cnt_q + GATE_W'(1);
      edge_cnt_q <= edge_next;
      sat_q      <= sat_next;
    end
  end

  // Result registers: latch the completed window and pulse freq_valid for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= gate_end;
      if (gate_end) begin
        freq_q <= edge_next;
        ovf_q  <= sat_next;
      end
    end
  end

  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter
module tb_freq_meter;

  localparam int G    = 100;
  localparam int MAXC = 8192;

  typedef struct {
    int edge_i;
    int f8;
    bit o8;
    int f3;
    bit o3;
    bit v3;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n, en, sig_in;
  logic [7:0] f8;
  logic       v8, o8, b8;
  logic [2:0] f3;
  logic       v3, o3, b3;

  freq_meter #(.CLK_HZ(100), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(f8), .freq_valid(v8), .ovf(o8), .busy(b8)
  );

  freq_meter #(.CLK_HZ(100), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(f3), .freq_valid(v3), .ovf(o3), .busy(b3)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   samp [MAXC];
  bit   rstv [MAXC];
  bit   m_open = 0;
  int   m_start = 0;
  int   exp_edge_q[$];
  int   exp_cnt_q[$];
  obs_t obs_q[$];
  int   nvalid = 0;
  int   dbl = 0;
  bit   prev_v8 = 0;
  int   wmode = 0;
  int   wleft = 0;
  int   sq_half = 5;
  logic hold_lvl = 1'b0;

  // Reference: a rise is sig_in sampled 1 after a 0 sample, both samples taken with the
  // meter out of reset long enough (reset cleared through edge k+2 discards it).
  function automatic int rises(int lo, int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) begin
      if (k >= 1 && k + 2 < MAXC) begin
        if (samp[k] && !samp[k-1] && rstv[k-1] && rstv[k] && rstv[k+1] && rstv[k+2]) n++;
      end
    end
    return n;
  endfunction

  // Reference gate timeline: a window opens on the first edge with en high and closes
  // G edges later; a rise sampled at edge k is counted at edge k+3.
  always @(posedge clk) begin
    if (cyc < MAXC) begin
      samp[cyc] = sig_in;
      rstv[cyc] = rst_n;
    end
    if (!rst_n || !en) begin
      m_open = 0;
    end else if (!m_open) begin
      m_open  = 1;
      m_start = cyc;
    end else if (cyc - m_start == G) begin
      exp_edge_q.push_back(cyc);
      exp_cnt_q.push_back(rises(m_start - 2, m_start + G - 3));
      m_start = cyc;
    end
    cyc++;
  end

  function automatic int sat8(int c);
    return (c > 255) ? 255 : c;
  endfunction

  function automatic int sat3(int c);
    return (c > 7) ? 7 : c;
  endfunction

  task automatic gen_sig();
    if (wmode == 0) begin
      sig_in = hold_lvl;
    end else begin
      wleft--;
      if (wleft <= 0) begin
        sig_in = ~sig_in;
        wleft = (wmode == 1) ? sq_half : int'($urandom_range(2, 6));
      end
    end
  endtask

  task automatic tick();
    obs_t o;
    @(negedge clk);
    if (v8) begin
      o.edge_i = cyc - 1;
      o.f8 = int'(f8);
      o.o8 = o8;
      o.f3 = int'(f3);
      o.o3 = o3;
      o.v3 = v3;
      obs_q.push_back(o);
      nvalid++;
    end
    if (v8 && prev_v8) dbl++;
    prev_v8 = v8;
    gen_sig();
  endtask

  task automatic wait_until(int k);
    while (cyc < k) tick();
  endtask

  task automatic set_hold(logic lvl);
    wmode = 0;
    hold_lvl = lvl;
    sig_in = lvl;
  endtask

  task automatic wait_report(output obs_t o, output int xe, output int xc, output bit ok);
    int guard = 0;
    while (obs_q.size() == 0 && guard < 300) begin
      tick();
      guard++;
    end
    ok = (obs_q.size() != 0) && (exp_edge_q.size() != 0);
    o = '{default: 0};
    xe = -1;
    xc = 0;
    if (obs_q.size() != 0) o = obs_q.pop_front();
    if (exp_edge_q.size() != 0) begin
      xe = exp_edge_q.pop_front();
      xc = exp_cnt_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; set_hold(1'b0);
    repeat (4) tick();
    tests++; if (f8 !== 8'd0) begin fails++; $display("FAIL reset_freq8: got %0d want 0", f8); end
    tests++; if (v8 !== 1'b0) begin fails++; $display("FAIL reset_valid8: got %b want 0", v8); end
    tests++; if (o8 !== 1'b0) begin fails++; $display("FAIL reset_ovf8: got %b want 0", o8); end
    tests++; if (b8 !== 1'b0) begin fails++; $display("FAIL reset_busy8: got %b want 0", b8); end
    tests++; if (f3 !== 3'd0 || o3 !== 1'b0 || b3 !== 1'b0) begin
      fails++; $display("FAIL reset_dut3: got f=%0d o=%b b=%b want 0 0 0", f3, o3, b3);
    end
    en = 1'b0;
    tick();
    obs_q.delete(); exp_edge_q.delete(); exp_cnt_q.delete();
  endtask

  task automatic test_square();
    obs_t o; int xe, xc, prev_e; bit ok;
    rst_n = 1'b1;
    wmode = 1; sq_half = 5; wleft = 5;
    repeat (20) tick();
    en = 1'b1;
    tick();
    tests++; if (b8 !== 1'b1) begin fails++; $display("FAIL sq_busy: got %b want 1", b8); end
    prev_e = -1;
    for (int i = 0; i < 4; i++) begin
      wait_report(o, xe, xc, ok);
      tests++; if (!ok) begin fails++; $display("FAIL sq_report%0d: got none want edge %0d", i, xe); continue; end
      tests++; if (o.edge_i !== xe) begin fails++; $display("FAIL sq_edge%0d: got %0d want %0d", i, o.edge_i, xe); end
      tests++; if (o.f8 !== 10 || o.o8 !== 1'b0) begin
        fails++; $display("FAIL sq_freq%0d: got %0d ovf %b want 10 ovf 0", i, o.f8, o.o8);
      end
      if (prev_e >= 0) begin
        tests++; if (o.edge_i - prev_e !== G) begin fails++; $display("FAIL sq_period%0d: got %0d want %0d", i, o.edge_i - prev_e, G); end
      end
      prev_e = o.edge_i;
      tick();
      tests++; if (v8 !== 1'b0) begin fails++; $display("FAIL sq_pulse_width%0d: got %b want 0", i, v8); end
    end
  endtask

  task automatic test_random();
    obs_t o; int xe, xc; bit ok;
    wmode = 2; wleft = 3;
    for (int i = 0; i < 5; i++) begin
      wait_report(o, xe, xc, ok);
      tests++; if (!ok) begin fails++; $display("FAIL rnd_report%0d: got none want edge %0d", i, xe); continue; end
      tests++; if (o.edge_i !== xe || o.f8 !== sat8(xc) || o.o8 !== (xc > 255)) begin
        fails++; $display("FAIL rnd_dut8_%0d: got e=%0d f=%0d o=%b want e=%0d f=%0d o=%b",
                          i, o.edge_i, o.f8, o.o8, xe, sat8(xc), xc > 255);
      end
      tests++; if (o.f3 !== sat3(xc) || o.o3 !== (xc > 7)) begin
        fails++; $display("FAIL rnd_dut3_%0d: got f=%0d o=%b want f=%0d o=%b", i, o.f3, o.o3, sat3(xc), xc > 7);
      end
    end
  endtask

  task automatic test_boundary();
    obs_t o; int xe, xc, e0; bit ok;
    set_hold(1'b0);
    wait_report(o, xe, xc, ok);
    e0 = xe;
    wait_until(e0 + 97); set_hold(1'b1);
    wait_until(e0 + 100); set_hold(1'b0);
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.edge_i !== e0 + 100 || o.f8 !== 1 || xc !== 1) begin
      fails++; $display("FAIL bnd_last_cycle: got e=%0d f=%0d want e=%0d f=1", o.edge_i, o.f8, e0 + 100);
    end
    wait_until(e0 + 198); set_hold(1'b1);
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.edge_i !== e0 + 200 || o.f8 !== 0 || xc !== 0) begin
      fails++; $display("FAIL bnd_not_early: got e=%0d f=%0d want e=%0d f=0", o.edge_i, o.f8, e0 + 200);
    end
    wait_until(e0 + 203); set_hold(1'b0);
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.edge_i !== e0 + 300 || o.f8 !== 1 || xc !== 1) begin
      fails++; $display("FAIL bnd_first_cycle: got e=%0d f=%0d want e=%0d f=1", o.edge_i, o.f8, e0 + 300);
    end
  endtask

  task automatic test_saturation();
    obs_t o; int xe, xc; bit ok;
    wmode = 1; sq_half = 2; wleft = 2;
    wait_report(o, xe, xc, ok);
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.f8 !== sat8(xc) || o.f3 !== sat3(xc) || o.o3 !== (xc > 7)) begin
      fails++; $display("FAIL sat_ramp: got f8=%0d f3=%0d o3=%b want f8=%0d f3=%0d o3=%b",
                        o.f8, o.f3, o.o3, sat8(xc), sat3(xc), xc > 7);
    end
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.f8 !== 25 || o.o8 !== 1'b0) begin
      fails++; $display("FAIL sat_dut8: got f=%0d o=%b want f=25 o=0", o.f8, o.o8);
    end
    tests++; if (o.f3 !== 7 || o.o3 !== 1'b1 || o.v3 !== 1'b1) begin
      fails++; $display("FAIL sat_dut3: got f=%0d o=%b v=%b want f=7 o=1 v=1", o.f3, o.o3, o.v3);
    end
    set_hold(1'b0);
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.f3 !== sat3(xc) || o.o3 !== (xc > 7)) begin
      fails++; $display("FAIL sat_tail: got f3=%0d o3=%b want f3=%0d o3=%b", o.f3, o.o3, sat3(xc), xc > 7);
    end
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.f3 !== 0 || o.o3 !== 1'b0 || o.f8 !== 0 || o.o8 !== 1'b0) begin
      fails++; $display("FAIL sat_clear: got f3=%0d o3=%b f8=%0d want 0 0 0", o.f3, o.o3, o.f8);
    end
  endtask

  task automatic test_abort();
    obs_t o; int xe, xc, r, nv, s, last_f; bit ok, last_o;
    wmode = 2; wleft = 2;
    wait_report(o, xe, xc, ok);
    r = xe; last_f = sat8(xc); last_o = (xc > 255);
    wait_until(r + 50); en = 1'b0;
    nv = nvalid;
    tick();
    tests++; if (b8 !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", b8); end
    repeat (120) tick();
    tests++; if (nvalid !== nv) begin fails++; $display("FAIL abort_no_valid: got %0d pulses want 0", nvalid - nv); end
    tests++; if (int'(f8) !== last_f || o8 !== last_o) begin
      fails++; $display("FAIL abort_hold: got f=%0d o=%b want f=%0d o=%b", f8, o8, last_f, last_o);
    end
    s = cyc; en = 1'b1;
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.edge_i !== s + G || xe !== s + G || o.f8 !== sat8(xc)) begin
      fails++; $display("FAIL abort_regate: got e=%0d f=%0d want e=%0d f=%0d", o.edge_i, o.f8, s + G, sat8(xc));
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; int xe, xc, r, rs, nv; bit ok;
    wait_report(o, xe, xc, ok);
    r = xe;
    wait_until(r + 40);
    rst_n = 1'b0; set_hold(1'b1);
    nv = nvalid;
    repeat (3) tick();
    tests++; if (f8 !== 8'd0 || o8 !== 1'b0 || b8 !== 1'b0 || v8 !== 1'b0 || f3 !== 3'd0) begin
      fails++; $display("FAIL rst_mid_out: got f=%0d o=%b b=%b v=%b want 0", f8, o8, b8, v8);
    end
    tests++; if (nvalid !== nv) begin fails++; $display("FAIL rst_mid_valid: got %0d pulses want 0", nvalid - nv); end
    rs = cyc; rst_n = 1'b1;
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.edge_i !== rs + G || o.f8 !== 0 || xc !== 0) begin
      fails++; $display("FAIL rst_mid_held_high: got e=%0d f=%0d want e=%0d f=0", o.edge_i, o.f8, rs + G);
    end
    wmode = 2; wleft = 2;
    wait_report(o, xe, xc, ok);
    tests++; if (!ok || o.edge_i !== xe || o.f8 !== sat8(xc)) begin
      fails++; $display("FAIL rst_mid_after: got e=%0d f=%0d want e=%0d f=%0d", o.edge_i, o.f8, xe, sat8(xc));
    end
    tests++; if (dbl !== 0) begin fails++; $display("FAIL back_to_back_valid: got %0d want 0", dbl); end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_square();
    test_random();
    test_boundary();
    test_saturation();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
